// File: rtl/acq_capture.sv
// acq_capture: triggered ADC acquisition writer (delay after start, channel select, run into BRAM until full).
// Define ACQ_CAPTURE_DECIMATION_EN to keep only one of every decimator+1 valid words.
module acq_capture #(
   parameter int DATA_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 10,
   parameter int DELAY_WIDTH = 16,
   parameter int DEC_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [DATA_WIDTH-1:0]  adc0,
   input  logic [DATA_WIDTH-1:0]  adc1,
   input  logic                   adcvalid,
   input  logic                   chansel,
   input  logic                   stb_start,
   input  logic                   acqbufreset,
   input  logic [DELAY_WIDTH-1:0] delayaftertrig,
   input  logic [DEC_WIDTH-1:0]   decimator,
   output logic                   wr_en,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   output logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   busy,
   output logic                   done,
   output logic [ADDR_WIDTH:0]    addr_mon
);
   typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_t;
   state_t                 state_q, state_d;
   logic                   chan_q, chan_d;
   logic [DELAY_WIDTH-1:0] dly_q, dly_d;
   logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                   keep, start, write;
`ifdef ACQ_CAPTURE_DECIMATION_EN
   logic [DEC_WIDTH-1:0]   dec_q, dec_d, deccnt_q, deccnt_d;
   assign keep = deccnt_q == '0;
   always_comb begin
      dec_d = start ? decimator : dec_q;
      deccnt_d = deccnt_q;
      if (acqbufreset || start)
         deccnt_d = '0;
      else if (state_q == CAPTURE && adcvalid && !cnt_q[ADDR_WIDTH])
         deccnt_d = keep ? dec_q : deccnt_q - DEC_WIDTH'(1);
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dec_q <= '0;
         deccnt_q <= '0;
      end else begin
         dec_q <= dec_d;
         deccnt_q <= deccnt_d;
      end
   end
`else
   logic unused_dec;
   assign unused_dec = ^decimator;
   assign keep = 1'b1;
`endif
   assign start = stb_start && (state_q == IDLE || state_q == DONE);
   // cnt_q MSB set means the buffer is full; no more writes and the run ends next cycle
   assign write = state_q == CAPTURE && adcvalid && keep && !cnt_q[ADDR_WIDTH];
   always_comb begin
      state_d = state_q;
      chan_d = chan_q;
      dly_d = dly_q;
      cnt_d = cnt_q + (ADDR_WIDTH+1)'(write);
      wr_en_d = write;
      wr_addr_d = write ? cnt_q[ADDR_WIDTH-1:0] : wr_addr_q;
      wr_data_d = write ? (chan_q ? adc1 : adc0) : wr_data_q;
      if (acqbufreset) begin
         state_d = IDLE;
         cnt_d = '0;
         wr_en_d = 1'b0;
      end else if (start) begin
         state_d = delayaftertrig != '0 ? DELAY : CAPTURE;
         chan_d = chansel;
         dly_d = delayaftertrig;
         cnt_d = '0;
      end else if (state_q == DELAY) begin
         dly_d = dly_q - DELAY_WIDTH'(1);
         state_d = dly_q == DELAY_WIDTH'(1) ? CAPTURE : DELAY;
      end else if (state_q == CAPTURE && cnt_q[ADDR_WIDTH])
         state_d = DONE;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         chan_q <= 1'b0;
         dly_q <= '0;
         cnt_q <= '0;
         wr_en_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q <= state_d;
         chan_q <= chan_d;
         dly_q <= dly_d;
         cnt_q <= cnt_d;
         wr_en_q <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end
   assign wr_en = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy = state_q == DELAY || state_q == CAPTURE;
   assign done = state_q == DONE;
   assign addr_mon = cnt_q;
endmodule

// File: tb/tb_acq_capture.sv
// tb_acq_capture: randomized runs; expected BRAM writes are queued by a run model and popped by a write monitor.
module tb_acq_capture;
   localparam int DW = 32, AW = 4, DEPTH = 16;
   logic clk = 0, resetn = 0, adcvalid = 0, chansel = 0, stb_start = 0, acqbufreset = 0;
   logic [DW-1:0] adc0 = '0, adc1 = '0;
   logic [15:0] delayaftertrig = '0;
   logic [7:0] decimator = '0;
   logic wr_en, busy, done;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0] addr_mon;
   typedef struct {int cyc; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
   wr_t exp_q[$];
   wr_t e;
   int cyc = 0, errors = 0, checks = 0;

   always #5 clk = ~clk;

   acq_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELAY_WIDTH(16), .DEC_WIDTH(8)) dut (
      .clk(clk), .resetn(resetn), .adc0(adc0), .adc1(adc1), .adcvalid(adcvalid),
      .chansel(chansel), .stb_start(stb_start), .acqbufreset(acqbufreset),
      .delayaftertrig(delayaftertrig), .decimator(decimator), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .addr_mon(addr_mon)
   );

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Monitor: every wr_en pulse must match the oldest expected write, and none may be skipped.
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) chk("unexpected_write", wr_en, 1'b0);
         else begin
            e = exp_q.pop_front();
            chk("write_cycle", cyc, e.cyc);
            chk("write_addr", wr_addr, e.addr);
            chk("write_data", wr_data, e.data);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         chk("missed_write", wr_en, 1'b1);
         void'(exp_q.pop_front());
      end
   end

   // kind: 0 full run to DONE, 1 acqbufreset+stb_start after 7 writes, 2 resetn pulse after 7 writes
   task automatic run(int d, bit ch, int dec, int vm, int kind, bit dup);
      bit v[$];
      logic [DW-1:0] a0[$], a1[$];
      int t = cyc, k = 0, nv = 0, last = 0, de = 0;
      int ncap = kind == 0 ? DEPTH : 7;
`ifdef ACQ_CAPTURE_DECIMATION_EN
      de = dec;
`endif
      for (int r = 0; k < ncap; r++) begin
         bit vv = vm == 0 ? 1'b1 : vm == 1 ? ((r - 1 - d) % 2 == 0) : ($urandom_range(3) != 0);
         v.push_back(vv);
         a0.push_back($urandom);
         a1.push_back($urandom);
         if (r > d && vv) begin
            if (nv % (de + 1) == 0) begin
               exp_q.push_back('{t + r + 1, k[AW-1:0], ch ? a1[r] : a0[r]});
               k++;
               last = r + 1;
            end
            nv++;
         end
      end
      for (int r = 0; r <= last; r++) begin
         stb_start = r == 0 || (dup && $urandom_range(2) == 0) || (r == last && kind == 1);
         chansel = r == 0 ? ch : 1'($urandom);
         decimator = r == 0 ? 8'(dec) : 8'($urandom);
         delayaftertrig = r == 0 ? 16'(d) : 16'($urandom);
         adcvalid = r < v.size() ? v[r] : 1'b1;
         adc0 = r < a0.size() ? a0[r] : $urandom;
         adc1 = r < a1.size() ? a1[r] : $urandom;
         if (r >= 1) begin
            chk("busy_in_run", busy, 1'b1);
            chk("done_in_run", done, 1'b0);
         end
         if (r == last) chk("addr_mon_last_write", addr_mon, ncap);
         if (r == last && kind == 1) acqbufreset = 1;
         if (r == last && kind == 2) resetn = 0;
         step();
      end
      stb_start = 0;
      if (kind == 0) begin
         chk("done_after_full", done, 1'b1);
         chk("busy_after_full", busy, 1'b0);
         chk("addr_mon_full", addr_mon, DEPTH);
         chk("wr_en_in_done", wr_en, 1'b0);
      end else begin
         acqbufreset = 0;
         resetn = 1;
         adcvalid = 1;
         chk("abort_wr_en", wr_en, 1'b0);
         chk("abort_busy", busy, 1'b0);
         chk("abort_done", done, 1'b0);
         chk("abort_addr_mon", addr_mon, 0);
         if (kind == 2) begin
            chk("reset_wr_addr", wr_addr, 0);
            chk("reset_wr_data", wr_data, 0);
         end
         repeat (3) begin
            step();
            chk("no_restart", busy, 1'b0);
         end
      end
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      repeat (2) step();
      chk("reset_wr_en", wr_en, 1'b0);
      chk("reset_wr_addr", wr_addr, 0);
      chk("reset_wr_data", wr_data, 0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_addr_mon", addr_mon, 0);
      resetn = 1;
      step();
      run(0, 0, 0, 0, 0, 0);
      run(5, 1, 0, 0, 0, 1);
      run(0, 0, 2, 1, 0, 0);
      run(3, 1, 1, 2, 0, 1);
      step();
      run(2, 0, 0, 0, 1, 0);
      run(0, 1, 3, 2, 0, 0);
      run(1, 0, 1, 2, 2, 0);
      for (int i = 0; i < 4; i++)
         run($urandom_range(6), 1'($urandom), $urandom_range(3), 2, 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
